// File: rtl/two_d_denormalize.sv
// Rescales a sign-magnitude (x,y) vector of length d to length len: out = comp*len/d per component.
// One restoring divider is time-shared between x and y behind valid/ready handshakes.
module two_d_denormalize #(
    parameter int MAG_W = 10,
    parameter int LEN_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LEN_W-1:0]       d,
    input  logic [LEN_W-1:0]       len,
    input  logic [2*(MAG_W+1)-1:0] dir,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [MAG_W:0]         scaled_x,
    output logic [MAG_W:0]         scaled_y,
    output logic                   sat,
    output logic                   err
);
    localparam int P_W   = MAG_W + LEN_W;
    localparam int CNT_W = $clog2(P_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(P_W - 1);
    localparam logic [P_W-1:0]   Q_MAX    = P_W'((2 ** MAG_W) - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PREP  = 3'd1,
        S_DIV_X = 3'd2,
        S_DIV_Y = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    function automatic logic [MAG_W-1:0] clamp_mag(input logic [P_W-1:0] q);
        logic [MAG_W-1:0] m;
        if (q > Q_MAX) begin
            m = Q_MAX[MAG_W-1:0];
        end else begin
            m = q[MAG_W-1:0];
        end
        return m;
    endfunction

    // A zero magnitude never carries a negative sign.
    function automatic logic [MAG_W:0] pack_sm(input logic s, input logic [MAG_W-1:0] m);
        return {s && (m != {MAG_W{1'b0}}), m};
    endfunction

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [LEN_W-1:0]   d_q, d_d, len_q, len_d;
    logic               sx_q, sx_d, sy_q, sy_d;
    logic [MAG_W-1:0]   mx_q, mx_d, my_q, my_d;
    logic [P_W-1:0]     py_q, py_d, div_q, div_d, quot_q, quot_d, qx_q, qx_d;
    logic [LEN_W:0]     rem_q, rem_d;
    logic               in_ready_q, in_ready_d, out_valid_q, out_valid_d;
    logic [MAG_W:0]     scaled_x_q, scaled_x_d, scaled_y_q, scaled_y_d;
    logic               sat_q, sat_d, err_q, err_d;

    logic [P_W-1:0]     px_s, py_s, quot_nx_s;
    logic [LEN_W:0]     rem_sh_s, rem_nx_s;
    logic               ge_s;

    // Products and one restoring-division step on the current partial remainder.
    always_comb begin
        px_s      = P_W'(mx_q) * P_W'(len_q);
        py_s      = P_W'(my_q) * P_W'(len_q);
        rem_sh_s  = {rem_q[LEN_W-1:0], div_q[P_W-1]};
        ge_s      = (rem_sh_s >= {1'b0, d_q});
        rem_nx_s  = ge_s ? (rem_sh_s - {1'b0, d_q}) : rem_sh_s;
        quot_nx_s = {quot_q[P_W-2:0], ge_s};
    end

    // Next-state and datapath control.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        d_d         = d_q;
        len_d       = len_q;
        sx_d        = sx_q;
        sy_d        = sy_q;
        mx_d        = mx_q;
        my_d        = my_q;
        py_d        = py_q;
        div_d       = div_q;
        quot_d      = quot_q;
        qx_d        = qx_q;
        rem_d       = rem_q;
        out_valid_d = out_valid_q;
        scaled_x_d  = scaled_x_q;
        scaled_y_d  = scaled_y_q;
        sat_d       = sat_q;
        err_d       = err_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready_q) begin
                    d_d     = d;
                    len_d   = len;
                    sx_d    = dir[2*MAG_W+1];
                    mx_d    = dir[2*MAG_W:MAG_W+1];
                    sy_d    = dir[MAG_W];
                    my_d    = dir[MAG_W-1:0];
                    state_d = S_PREP;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_PREP: begin
                if (d_q == {LEN_W{1'b0}}) begin
                    state_d = S_DONE;
                end else begin
                    div_d   = px_s;
                    py_d    = py_s;
                    rem_d   = {(LEN_W+1){1'b0}};
                    quot_d  = {P_W{1'b0}};
                    cnt_d   = {CNT_W{1'b0}};
                    state_d = S_DIV_X;
                end
            end
            S_DIV_X, S_DIV_Y: begin
                div_d  = {div_q[P_W-2:0], 1'b0};
                rem_d  = rem_nx_s;
                quot_d = quot_nx_s;
                if (cnt_q != CNT_LAST) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else if (state_q == S_DIV_X) begin
                    qx_d    = quot_nx_s;
                    div_d   = py_q;
                    rem_d   = {(LEN_W+1){1'b0}};
                    quot_d  = {P_W{1'b0}};
                    cnt_d   = {CNT_W{1'b0}};
                    state_d = S_DIV_Y;
                end else begin
                    scaled_x_d  = pack_sm(sx_q, clamp_mag(qx_q));
                    scaled_y_d  = pack_sm(sy_q, clamp_mag(quot_nx_s));
                    sat_d       = (qx_q > Q_MAX) || (quot_nx_s > Q_MAX);
                    err_d       = 1'b0;
                    out_valid_d = 1'b1;
                    state_d     = S_DONE;
                end
            end
            S_DONE: begin
                // Only the divide-by-zero path arrives here without a result presented.
                if (!out_valid_q) begin
                    scaled_x_d  = {(MAG_W+1){1'b0}};
                    scaled_y_d  = {(MAG_W+1){1'b0}};
                    sat_d       = 1'b0;
                    err_d       = 1'b1;
                    out_valid_d = 1'b1;
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = S_IDLE;
            end
        endcase
        in_ready_d = (state_d == S_IDLE);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= {CNT_W{1'b0}};
            d_q         <= {LEN_W{1'b0}};
            len_q       <= {LEN_W{1'b0}};
            sx_q        <= 1'b0;
            sy_q        <= 1'b0;
            mx_q        <= {MAG_W{1'b0}};
            my_q        <= {MAG_W{1'b0}};
            py_q        <= {P_W{1'b0}};
            div_q       <= {P_W{1'b0}};
            quot_q      <= {P_W{1'b0}};
            qx_q        <= {P_W{1'b0}};
            rem_q       <= {(LEN_W+1){1'b0}};
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            scaled_x_q  <= {(MAG_W+1){1'b0}};
            scaled_y_q  <= {(MAG_W+1){1'b0}};
            sat_q       <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            d_q         <= d_d;
            len_q       <= len_d;
            sx_q        <= sx_d;
            sy_q        <= sy_d;
            mx_q        <= mx_d;
            my_q        <= my_d;
            py_q        <= py_d;
            div_q       <= div_d;
            quot_q      <= quot_d;
            qx_q        <= qx_d;
            rem_q       <= rem_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            scaled_x_q  <= scaled_x_d;
            scaled_y_q  <= scaled_y_d;
            sat_q       <= sat_d;
            err_q       <= err_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign scaled_x  = scaled_x_q;
    assign scaled_y  = scaled_y_q;
    assign sat       = sat_q;
    assign err       = err_q;
endmodule

// File: tb/tb_two_d_denormalize.sv
// Directed self-checking bench for two_d_denormalize at default parameters.
module tb_two_d_denormalize;
    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, out_valid, out_ready, sat, err;
    logic [7:0]  d, len;
    logic [21:0] dir;
    logic [10:0] scaled_x, scaled_y;
    int          checks = 0;
    int          failures = 0;
    int          lat;

    two_d_denormalize dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .d(d), .len(len), .dir(dir), .out_valid(out_valid), .out_ready(out_ready),
        .scaled_x(scaled_x), .scaled_y(scaled_y), .sat(sat), .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [21:0] mk(input logic sx, input int mx, input logic sy, input int my);
        return {sx, 10'(mx), sy, 10'(my)};
    endfunction

    // Present one request, accept it, scramble inputs, and return edges until out_valid (0 = timeout).
    task automatic send_req(input logic [7:0] dv, input logic [7:0] lv, input logic [21:0] dr, output int l);
        @(negedge clk);
        in_valid = 1'b1; d = dv; len = lv; dir = dr;
        @(posedge clk);
        #1;
        in_valid = 1'b0; d = 8'hFF; len = 8'hFF; dir = 22'h3FFFFF;
        l = 0;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                l = k;
                break;
            end
        end
    endtask

    task automatic ack();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; d = 8'd0; len = 8'd0; dir = 22'd0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if ({scaled_x, scaled_y, sat, err} !== 24'd0) begin failures++;
            $display("FAIL reset_outputs got x=%h y=%h sat=%b err=%b exp all 0", scaled_x, scaled_y, sat, err); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic();
        send_req(8'd100, 8'd50, mk(1'b0, 60, 1'b1, 80), lat);
        checks++; if (lat !== 37) begin failures++; $display("FAIL basic_latency got=%0d exp=37", lat); end
        checks++; if (scaled_x !== {1'b0, 10'd30}) begin failures++; $display("FAIL basic_x got=%h exp=%h", scaled_x, {1'b0, 10'd30}); end
        checks++; if (scaled_y !== {1'b1, 10'd40}) begin failures++; $display("FAIL basic_y got=%h exp=%h", scaled_y, {1'b1, 10'd40}); end
        checks++; if ({sat, err} !== 2'b00) begin failures++; $display("FAIL basic_flags got=%b%b exp=00", sat, err); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL basic_busy_in_ready got=%b exp=0", in_ready); end
        ack();
        checks++; if ({out_valid, in_ready} !== 2'b01) begin failures++; $display("FAIL basic_after_ack got v=%b r=%b exp v=0 r=1", out_valid, in_ready); end
    endtask

    task automatic test_trunc_sign();
        send_req(8'd3, 8'd1, mk(1'b1, 2, 1'b1, 5), lat);
        checks++; if (lat !== 37) begin failures++; $display("FAIL trunc_latency got=%0d exp=37", lat); end
        checks++; if (scaled_x !== 11'd0) begin failures++; $display("FAIL trunc_neg_zero_x got=%h exp=000", scaled_x); end
        checks++; if (scaled_y !== {1'b1, 10'd1}) begin failures++; $display("FAIL trunc_y got=%h exp=%h", scaled_y, {1'b1, 10'd1}); end
        ack();
    endtask

    task automatic test_saturate();
        send_req(8'd1, 8'd255, mk(1'b0, 1023, 1'b0, 0), lat);
        checks++; if (lat !== 37) begin failures++; $display("FAIL sat_latency got=%0d exp=37", lat); end
        checks++; if (scaled_x !== {1'b0, 10'd1023}) begin failures++; $display("FAIL sat_x got=%h exp=%h", scaled_x, {1'b0, 10'd1023}); end
        checks++; if (scaled_y !== 11'd0) begin failures++; $display("FAIL sat_y got=%h exp=000", scaled_y); end
        checks++; if ({sat, err} !== 2'b10) begin failures++; $display("FAIL sat_flags got=%b%b exp=10", sat, err); end
        ack();
    endtask

    task automatic test_div_zero();
        send_req(8'd0, 8'd7, mk(1'b0, 5, 1'b0, 5), lat);
        checks++; if (lat !== 2) begin failures++; $display("FAIL dz_latency got=%0d exp=2", lat); end
        checks++; if ({scaled_x, scaled_y} !== 22'd0) begin failures++; $display("FAIL dz_outputs got x=%h y=%h exp 0", scaled_x, scaled_y); end
        checks++; if ({sat, err} !== 2'b01) begin failures++; $display("FAIL dz_flags got=%b%b exp=01", sat, err); end
        ack();
    endtask

    task automatic test_back_to_back();
        int bad;
        send_req(8'd200, 8'd100, mk(1'b0, 500, 1'b1, 1000), lat);
        checks++; if (lat !== 37) begin failures++; $display("FAIL hold_latency got=%0d exp=37", lat); end
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if ({out_valid, in_ready, scaled_x, scaled_y} !== {2'b10, 1'b0, 10'd250, 1'b1, 10'd500}) bad++;
        end
        checks++; if (bad !== 0) begin failures++; $display("FAIL hold_stable got=%0d unstable cycles exp=0", bad); end
        @(negedge clk);
        out_ready = 1'b1; in_valid = 1'b1; d = 8'd7; len = 8'd9; dir = mk(1'b1, 100, 1'b0, 13);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checks++; if ({out_valid, in_ready} !== 2'b01) begin failures++; $display("FAIL b2b_handshake got v=%b r=%b exp v=0 r=1", out_valid, in_ready); end
        @(posedge clk);
        #1;
        in_valid = 1'b0; dir = 22'd0;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL b2b_accept got in_ready=%b exp=0", in_ready); end
        lat = 0;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin lat = k; break; end
        end
        checks++; if (lat !== 37) begin failures++; $display("FAIL b2b_latency got=%0d exp=37", lat); end
        checks++; if ({scaled_x, scaled_y} !== {1'b1, 10'd128, 1'b0, 10'd16}) begin failures++;
            $display("FAIL b2b_result got x=%h y=%h exp x=%h y=%h", scaled_x, scaled_y, {1'b1, 10'd128}, {1'b0, 10'd16}); end
        ack();
    endtask

    task automatic test_reset_mid_div();
        int seen;
        @(negedge clk);
        in_valid = 1'b1; d = 8'd100; len = 8'd50; dir = mk(1'b0, 60, 1'b1, 80);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checks++; if ({in_ready, out_valid} !== 2'b10) begin failures++; $display("FAIL midrst_state got r=%b v=%b exp r=1 v=0", in_ready, out_valid); end
        seen = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        checks++; if (seen !== 0) begin failures++; $display("FAIL midrst_abandon got=%0d valid cycles exp=0", seen); end
        send_req(8'd10, 8'd20, mk(1'b0, 7, 1'b1, 300), lat);
        checks++; if (lat !== 37) begin failures++; $display("FAIL midrst_fresh_latency got=%0d exp=37", lat); end
        checks++; if ({scaled_x, scaled_y, sat, err} !== {1'b0, 10'd14, 1'b1, 10'd600, 2'b00}) begin failures++;
            $display("FAIL midrst_fresh_result got x=%h y=%h sat=%b err=%b exp x=00e y=658 00", scaled_x, scaled_y, sat, err); end
        ack();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_trunc_sign();
        test_saturate();
        test_div_zero();
        test_back_to_back();
        test_reset_mid_div();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
